if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline; directly upstream of the IF/ID pipeline register struct (Curr_Pc, Curr_Instr).
- Owns the 9-bit fetch PC and drives a fixed 1-cycle-latency instruction memory.
- Buffers returned words in a 2-entry skid FIFO so hazard stalls never drop or duplicate instructions.
- Applies branch/jump redirects from EX and presents Curr_Pc/Curr_Instr plus a valid bit to decode.

Parameters:
- PC_W, 9, fetch PC / instruction address width (byte address; wraps mod 2^PC_W).
- INSTR_W, 32, instruction word width.
- RESET_PC, 9'h000, fetch PC after reset.
- NOP_INSTR, 32'h00000013, word driven on ifid_instr_o when the slot is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- stall_i  in  1  hazard unit: hold IF/ID outputs this cycle.
- redirect_i  in  1  EX: branch taken or jal/jalr; flush and refetch.
- redirect_pc_i  in  PC_W  redirect target.
- imem_req_o  out  1  read request this cycle.
- imem_addr_o  out  PC_W  read address (equals fetch PC).
- imem_rdata_i  in  INSTR_W  read data; valid exactly one cycle after the request.
- ifid_valid_o  out  1  IF/ID slot holds a real instruction.
- ifid_pc_o  out  PC_W  maps to Curr_Pc.
- ifid_instr_o  out  INSTR_W  maps to Curr_Instr.

Behaviour:
- Reset state, when reset=1 at an edge:
  - fetch_pc=RESET_PC; FIFO count=0; inflight=0.
  - ifid_valid_o=0; ifid_pc_o=0; ifid_instr_o=NOP_INSTR.
  - imem_req_o is forced 0 while reset is high.
- A reset mid-operation discards everything in flight and in the FIFO.
- Per-cycle internal terms:
  - pop = !stall_i && count>0.
  - issue = !reset && !redirect_i && (count + inflight - pop) < 2.
- imem_req_o = issue; imem_addr_o = fetch_pc.
- On issue: fetch_pc <= fetch_pc+4, truncated to PC_W so 9'h1FC wraps to 9'h000; inflight <= 1. Otherwise inflight <= 0.
- Return path: if inflight=1 and no redirect this cycle, push {pc_of_request, imem_rdata_i} into the FIFO at the end of the cycle. The request PC is held in a 1-entry pipeline register.
- FIFO: 2 entries, in-order.
  - Push and pop may occur in the same cycle.
  - Overflow is impossible by construction of the issue rule.
  - Verification asserts count<=2 and no push when count=2 without a pop.
- IF/ID output update:
  - pop: load FIFO head; ifid_valid_o <= 1.
  - no pop and stall_i=0: ifid_valid_o <= 0; ifid_instr_o <= NOP_INSTR; ifid_pc_o holds.
  - stall_i=1: all ifid_* hold.
- Redirect (priority over stall):
  - At the end of the redirect cycle: fetch_pc <= redirect_pc_i; count <= 0; inflight <= 0.
  - Data returning in the redirect cycle is discarded.
  - ifid_valid_o <= 0; ifid_instr_o <= NOP_INSTR.
  - No request is issued in the redirect cycle.
- Latency, with cycle 0 the first cycle after reset or redirect:
  - request in cycle 0; push at end of cycle 1; pop at end of cycle 2.
  - ifid_valid_o=1 in cycle 3.
  - Steady state thereafter: one instruction per cycle.
- Misaligned redirect target: low 2 bits are passed through unchanged; alignment is not checked here (EX raises the exception).

Test Plan:
- Reset release, stall_i=0, imem returns word=addr+32'h1000:
  - ifid_valid_o=0 in cycles 0–2.
  - cycle 3: pc 0x000, instr 0x1000; cycle 4: pc 0x004; cycle 5: pc 0x008.
  - ifid_valid_o never drops in cycles 3–5.
- stall_i=1 for 4 cycles starting while pc 0x008 is in IF/ID:
  - outputs hold 0x008 for all 4 cycles; imem_req_o drops once count=2.
  - after release the sequence is 0x00C, 0x010, ... with no gap, skip or duplicate.
- redirect_i=1, redirect_pc_i=0x040 in cycle N:
  - ifid_valid_o=0 in N+1..N+3.
  - imem_addr_o=0x040 with req=1 in N+1.
  - ifid_pc_o=0x040 valid in N+4.
  - nothing from the old stream appears in N+1..N+4.
- redirect_i and stall_i both high in the same cycle: redirect wins and the IF/ID slot becomes NOP/invalid.
- Redirect to 0x1FC: next fetch addresses are 0x1FC, 0x000.
- reset pulsed for 1 cycle with the FIFO full: all outputs return to reset values; fetch restarts at RESET_PC with 3-cycle latency.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle-latency imem,
// and buffers returned words in a 2-entry skid FIFO ahead of the IF/ID slot.
module if_fetch_stage #(
  parameter int                 PC_W      = 9,
  parameter int                 INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               ifid_valid_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o
);

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    req_pc;
  logic               inflight;
  logic [PC_W-1:0]    fifo_pc    [2];
  logic [INSTR_W-1:0] fifo_instr [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic               pop;
  logic               push;
  logic               issue;

  assign pop  = !stall_i && (count != 2'd0);
  assign push = inflight && !redirect_i;
  // Only request when the word can land: FIFO occupancy plus the word in
  // flight, minus what leaves this cycle, must stay below two.
  assign issue = !reset && !redirect_i &&
                 (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc;

  always_ff @(posedge clk) begin
    // NOTE: all state here is sequential, so every assignment is non-blocking.
    if (reset) begin
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_instr_o <= NOP_INSTR;
    end else if (redirect_i) begin
      // Redirect beats stall: flush everything, including the returning word.
      fetch_pc     <= redirect_pc_i;
      inflight     <= 1'b0;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP_INSTR;
    end else begin
      inflight <= issue;
      if (issue) fetch_pc <= fetch_pc + PC_W'(4);
      if (push)  wr_ptr   <= ~wr_ptr;
      if (pop)   rd_ptr   <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        ifid_valid_o <= 1'b1;
        ifid_pc_o    <= fifo_pc[rd_ptr];
        ifid_instr_o <= fifo_instr[rd_ptr];
      end else if (!stall_i) begin
        ifid_valid_o <= 1'b0;
        ifid_instr_o <= NOP_INSTR;
      end
    end
  end

  // NOTE: FIFO storage and the request-PC register are not reset; the
  // pointers and count decide what is live, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (issue) req_pc <= fetch_pc;
    if (push) begin
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_instr[wr_ptr] <= imem_rdata_i;
    end
  end

endmodule
